// File: rtl/nrz_pkg.sv
// nrz_pkg: shared receiver state type and default timing constants
package nrz_pkg;
    typedef enum logic [1:0] {IDLE, HIGH, LOW, ERRWAIT} rx_state_t;
    localparam int DEF_DATA_WIDTH     = 24;
    localparam int DEF_CNT_WIDTH      = 8;
    localparam int DEF_MIN_HIGH_TICKS = 2;
    localparam int DEF_THRESH_TICKS   = 5;
    localparam int DEF_MAX_HIGH_TICKS = 12;
    localparam int DEF_RESET_TICKS    = 40;
endpackage

// File: rtl/nrz_sync.sv
// nrz_sync: two-flop synchronizer bringing the asynchronous line into the clk domain
module nrz_sync (
    input  logic clk,
    input  logic reset,
    input  logic i_din,
    output logic o_din_s
);
    logic [1:0] r_sync;
    always_ff @(posedge clk or posedge reset)
        if (reset) r_sync <= '0;
        else r_sync <= {r_sync[0], i_din};
    assign o_din_s = r_sync[1];
endmodule

// File: rtl/nrz_rx.sv
// nrz_rx: pulse-width NRZ decoder; high time per clken tick selects the bit value,
// a long low gap ends the frame
module nrz_rx
    import nrz_pkg::*;
#(
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int MIN_HIGH_TICKS = DEF_MIN_HIGH_TICKS,
    parameter int THRESH_TICKS   = DEF_THRESH_TICKS,
    parameter int MAX_HIGH_TICKS = DEF_MAX_HIGH_TICKS,
    parameter int RESET_TICKS    = DEF_RESET_TICKS
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clken,
    input  logic                  din,
    output logic [DATA_WIDTH-1:0] dout,
    output logic                  valid,
    output logic                  latch,
    output logic                  err
);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [CNT_WIDTH-1:0] C_MIN = CNT_WIDTH'(MIN_HIGH_TICKS);
    localparam logic [CNT_WIDTH-1:0] C_THR = CNT_WIDTH'(THRESH_TICKS);
    localparam logic [CNT_WIDTH-1:0] C_MAX = CNT_WIDTH'(MAX_HIGH_TICKS);
    localparam logic [CNT_WIDTH-1:0] C_RST = CNT_WIDTH'(RESET_TICKS);
    localparam logic [CNT_WIDTH-1:0] C_SAT = '1;
    localparam logic [BW-1:0]        C_LAST = BW'(DATA_WIDTH - 1);

    if (MAX_HIGH_TICKS >= 2 ** CNT_WIDTH || RESET_TICKS >= 2 ** CNT_WIDTH) begin : g_bad_cnt
        $error("nrz_rx: MAX_HIGH_TICKS and RESET_TICKS must fit in CNT_WIDTH bits");
    end
    if (MIN_HIGH_TICKS > THRESH_TICKS || THRESH_TICKS >= MAX_HIGH_TICKS) begin : g_bad_thr
        $error("nrz_rx: need MIN_HIGH_TICKS <= THRESH_TICKS < MAX_HIGH_TICKS");
    end

    rx_state_t             r_state, w_state;
    logic [CNT_WIDTH-1:0]  r_tick, w_tick, w_tick_inc;
    logic [BW-1:0]         r_bitcnt, w_bitcnt;
    logic [DATA_WIDTH-1:0] r_shift, r_dout, w_shift_nxt;
    logic                  r_din_prev, r_valid, r_latch, r_err;
    logic                  w_din_s, w_rise, w_fall, w_shift, w_valid, w_latch, w_err;

    nrz_sync u_sync (
        .clk     (clk),
        .reset   (reset),
        .i_din   (din),
        .o_din_s (w_din_s)
    );

    assign w_rise      = w_din_s & ~r_din_prev;
    assign w_fall      = ~w_din_s & r_din_prev;
    assign w_tick_inc  = (r_tick == C_SAT) ? r_tick : r_tick + 1'b1;
    assign w_shift_nxt = {r_shift[DATA_WIDTH-2:0], w_tick_inc > C_THR};

    always_ff @(posedge clk or posedge reset)
        if (reset) r_state <= IDLE;
        else r_state <= w_state;

    // The fall tick itself counts toward the high time, so an N-tick pulse measures N.
    always_comb begin
        w_state  = r_state;
        w_tick   = r_tick;
        w_bitcnt = r_bitcnt;
        w_shift  = 1'b0;
        w_valid  = 1'b0;
        w_latch  = 1'b0;
        w_err    = 1'b0;
        if (clken) begin
            case (r_state)
                IDLE: if (w_rise) begin
                    w_tick  = '0;
                    w_state = HIGH;
                end
                HIGH: begin
                    w_tick = w_tick_inc;
                    if (w_tick_inc > C_MAX) begin
                        w_err    = 1'b1;
                        w_bitcnt = '0;
                        w_state  = w_fall ? IDLE : ERRWAIT;
                    end else if (w_fall) begin
                        w_tick  = '0;
                        w_state = LOW;
                        w_err   = w_tick_inc < C_MIN;
                        w_shift = ~w_err;
                        w_valid = w_shift && r_bitcnt == C_LAST;
                        w_bitcnt = w_valid ? '0 : w_shift ? r_bitcnt + 1'b1 : r_bitcnt;
                    end
                end
                LOW: if (w_rise) begin
                    w_tick  = '0;
                    w_state = HIGH;
                end else begin
                    w_tick = w_tick_inc;
                    if (w_tick_inc == C_RST) begin
                        w_latch  = 1'b1;
                        w_err    = r_bitcnt != '0;
                        w_bitcnt = '0;
                        w_state  = IDLE;
                    end
                end
                ERRWAIT: if (w_fall) w_state = IDLE;
                default: w_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            r_tick     <= '0;
            r_bitcnt   <= '0;
            r_shift    <= '0;
            r_dout     <= '0;
            r_din_prev <= 1'b0;
            r_valid    <= 1'b0;
            r_latch    <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            r_tick   <= w_tick;
            r_bitcnt <= w_bitcnt;
            r_valid  <= w_valid;
            r_latch  <= w_latch;
            r_err    <= w_err;
            if (clken) r_din_prev <= w_din_s;
            if (w_shift) r_shift <= w_shift_nxt;
            if (w_valid) r_dout <= w_shift_nxt;
        end

    assign dout  = r_dout;
    assign valid = r_valid;
    assign latch = r_latch;
    assign err   = r_err;
endmodule

// File: doc/nrz_rx.md
NRZ_RX -- requirements
Module: nrz_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 24, meaning bits per decoded word, shifted in MSB first.
REQ-002 SHALL have parameter CNT_WIDTH, default 8, meaning width of the tick counters.
REQ-003 SHALL have parameter MIN_HIGH_TICKS, default 2, meaning the shortest legal high pulse; shorter pulses are glitches.
REQ-004 SHALL have parameter THRESH_TICKS, default 5, meaning a high time above this value decodes as 1, otherwise 0.
REQ-005 SHALL have parameter MAX_HIGH_TICKS, default 12, meaning a high time above this value is a timing error.
REQ-006 SHALL have parameter RESET_TICKS, default 40, meaning the low time that ends a frame (latch gap).
REQ-007 SHALL have port clk, input, 1 bit, meaning the system clock.
REQ-008 SHALL have port reset, input, 1 bit, meaning reset; asynchronous, active-high.
REQ-009 SHALL have port clken, input, 1 bit, meaning the sampling tick; all timing is counted in clken ticks.
REQ-010 SHALL have port din, input, 1 bit, meaning the asynchronous serial NRZ line.
REQ-011 SHALL have port dout, output, DATA_WIDTH bits, meaning the decoded word, held stable until the next valid.
REQ-012 SHALL have port valid, output, 1 bit, meaning a one-clk pulse when dout is updated.
REQ-013 SHALL have port latch, output, 1 bit, meaning a one-clk pulse on latch-gap detection.
REQ-014 SHALL have port err, output, 1 bit, meaning a one-clk pulse on a glitch, overlong high or partial word.

Function
REQ-015 SHALL synchronize din through 2 flops (din_s); the sample din_prev SHALL update only on clken.
REQ-016 SHALL evaluate the FSM only on clken ticks: rise = din_s & ~din_prev, fall = ~din_s & din_prev.
REQ-017 SHALL use states IDLE, HIGH, LOW, ERRWAIT; after reset the FSM SHALL be in IDLE with bitcnt=0 and tickcnt=0.
REQ-018 SHALL, in IDLE on rise, clear tickcnt and go to HIGH; any other input SHALL keep the FSM in IDLE.
REQ-019 SHALL, in HIGH, increment tickcnt per tick (saturating at all-ones); tickcnt counts the ticks since the rise, starting at 1 on the first tick after the rise.
REQ-020 SHALL, in HIGH on fall with tickcnt < MIN_HIGH_TICKS, pulse err, leave the shift register and bitcnt unchanged, clear tickcnt and go to LOW.
REQ-021 SHALL, in HIGH on fall with tickcnt >= MIN_HIGH_TICKS, shift bit = (tickcnt > THRESH_TICKS) into the shift register LSB (word MSB first), increment bitcnt, clear tickcnt and go to LOW.
REQ-022 SHALL, when bitcnt reaches DATA_WIDTH, load dout from the shift register, pulse valid on the next clk, and wrap bitcnt to 0 in the same cycle.
REQ-023 SHALL, in HIGH when tickcnt exceeds MAX_HIGH_TICKS, pulse err, clear bitcnt and go to ERRWAIT.
REQ-024 SHALL, in ERRWAIT, go to IDLE on fall; no bits are decoded in ERRWAIT.
REQ-025 SHALL, in LOW, increment tickcnt per tick; on rise it SHALL clear tickcnt and go to HIGH.
REQ-026 SHALL, in LOW when tickcnt reaches RESET_TICKS, pulse latch, pulse err as well if bitcnt != 0, clear bitcnt and go to IDLE.
REQ-027 SHALL give rise priority when a rise and tickcnt==RESET_TICKS occur on the same tick (no latch).
REQ-028 SHALL, when valid and latch coincide on one clk, assert both.
REQ-029 SHALL do nothing on clk cycles without clken: no counting and no state change.
REQ-030 SHALL assert valid/latch/err for exactly one clk cycle each.
REQ-031 SHALL have latency from the last bit's fall tick to valid of 1 clk, plus the 2-clk synchronizer delay.

Reset
REQ-032 SHALL, on reset assertion, immediately clear dout=0, valid=0, latch=0, err=0, the shift register, bitcnt, tickcnt, din_prev and the synchronizer, and set the state to IDLE.
REQ-033 SHALL, when reset occurs mid-word, discard partial bits; the first word after reset is assembled from scratch.

Structure
REQ-034 SHALL place the state enum (rx_state_t) and the default timing constants in shared package nrz_pkg.
REQ-035 SHALL instantiate the 2-flop synchronizer as sub-module nrz_sync; counters and FSM SHALL remain in nrz_rx.
REQ-036 SHALL require MAX_HIGH_TICKS and RESET_TICKS < 2**CNT_WIDTH and MIN_HIGH_TICKS <= THRESH_TICKS < MAX_HIGH_TICKS, checked by elaboration assertions.

Verification
REQ-037 SHALL cover: clken every 4 clk, word 24'hA5C3F0 sent as high 3/low 8 ticks (0) and high 8/low 3 ticks (1) -> single valid with dout=24'hA5C3F0.
REQ-038 SHALL cover: two words back-to-back, then low for 40 ticks -> two valids (24'h123456, 24'hABCDEF), then one latch, no err.
REQ-039 SHALL cover: a 1-tick high pulse injected between bits 5 and 6 -> err pulse, following word still decoded correctly.
REQ-040 SHALL cover: a 13-tick high -> err, no valid until the line falls and a fresh word arrives; that word decodes correctly.
REQ-041 SHALL cover: 10 bits then a 40-tick low -> latch and err on the same clk, next 24-bit word correct.
REQ-042 SHALL cover: reset asserted mid-word (bit 12) -> all outputs 0 at once, next full word decoded correctly.
